// File: rtl/order_tx_sched.sv
// Two-source TX scheduler. It arbitrates between an ordered and an unordered queue head with a
// weighted priority. A busy-ID scoreboard limits outstanding IDs, and a registered output stage is
// released by ready.
module order_tx_sched #(
  parameter int ORD_WEIGHT      = 2,
  parameter int OUTSTANDING_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ord_valid_i,
  input  logic [2:0]  ord_id_i,
  input  logic [15:0] ord_payload_i,
  output logic        ord_ready_o,
  input  logic        unord_valid_i,
  input  logic [2:0]  unord_id_i,
  input  logic [15:0] unord_payload_i,
  output logic        unord_ready_o,
  output logic        tx_valid_o,
  output logic [2:0]  tx_id_o,
  output logic [15:0] tx_payload_o,
  output logic        tx_src_o,
  input  logic        tx_ready_i,
  input  logic        ret_i,
  input  logic [2:0]  ret_id_i,
  output logic [7:0]  busy_o,
  output logic [3:0]  outstanding_o
);

  typedef enum logic [1:0] {GNT_NONE, GNT_ORD, GNT_UNORD} gnt_e;

  localparam logic [2:0] WEIGHT  = 3'(ORD_WEIGHT);
  localparam logic [3:0] OUT_MAX = 4'(OUTSTANDING_MAX);

  logic [2:0] wcnt_q;
  logic       slot_free;
  logic       cap_ok;
  logic       ord_elig;
  logic       unord_elig;
  gnt_e       gnt;
  logic [7:0] busy_next;

  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < 8; i++) outstanding_o = outstanding_o + 4'(busy_o[i]);
  end

  // Eligibility uses only registered busy state, so a retire frees its ID one cycle later.
  assign slot_free  = ~tx_valid_o | tx_ready_i;
  assign cap_ok     = outstanding_o < OUT_MAX;
  assign ord_elig   = ord_valid_i & ~busy_o[ord_id_i] & cap_ok;
  assign unord_elig = unord_valid_i & ~busy_o[unord_id_i] & cap_ok;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt = GNT_NONE;
    if (slot_free) begin
      if (ord_elig && (!unord_elig || wcnt_q < WEIGHT)) gnt = GNT_ORD;
      else if (unord_elig)                              gnt = GNT_UNORD;
    end
  end

  assign ord_ready_o   = reset & (gnt == GNT_ORD);
  assign unord_ready_o = reset & (gnt == GNT_UNORD);

  // The granted ID is never busy, so letting the grant win over a retire is always correct.
  always_comb begin
    busy_next = busy_o;
    if (ret_i) busy_next[ret_id_i] = 1'b0;
    case (gnt)
      GNT_ORD:   busy_next[ord_id_i]   = 1'b1;
      GNT_UNORD: busy_next[unord_id_i] = 1'b1;
      default:   ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_o       <= '0;
      wcnt_q       <= '0;
      tx_valid_o   <= 1'b0;
      tx_id_o      <= '0;
      tx_payload_o <= '0;
      tx_src_o     <= 1'b0;
    end else begin
      busy_o <= busy_next;
      case (gnt)
        GNT_ORD: begin
          tx_valid_o   <= 1'b1;
          tx_id_o      <= ord_id_i;
          tx_payload_o <= ord_payload_i;
          tx_src_o     <= 1'b1;
          if (wcnt_q < WEIGHT) wcnt_q <= wcnt_q + 3'd1;
        end
        GNT_UNORD: begin
          tx_valid_o   <= 1'b1;
          tx_id_o      <= unord_id_i;
          tx_payload_o <= unord_payload_i;
          tx_src_o     <= 1'b0;
          wcnt_q       <= '0;
        end
        default: if (slot_free) tx_valid_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/order_tx_sched.md
ORDER_TX_SCHED -- requirements
Module: order_tx_sched

Interface
REQ-001 SHALL have parameter ORD_WEIGHT, default 2: maximum consecutive ordered grants while unordered is also eligible (legal 1..7).
REQ-002 SHALL have parameter OUTSTANDING_MAX, default 8: maximum issued-but-unretired IDs (legal 1..8).
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports ord_valid_i, input, 1; ord_id_i, input, 3; ord_payload_i, input, 16: head of ordered queue.
REQ-006 SHALL have port ord_ready_o, output, 1: ordered head accepted this cycle.
REQ-007 SHALL have ports unord_valid_i, input, 1; unord_id_i, input, 3; unord_payload_i, input, 16: head of unordered queue.
REQ-008 SHALL have port unord_ready_o, output, 1: unordered head accepted this cycle.
REQ-009 SHALL have ports tx_valid_o, output, 1; tx_id_o, output, 3; tx_payload_o, output, 16; tx_src_o, output, 1 (1 = ordered): registered TX stage.
REQ-010 SHALL have port tx_ready_i, input, 1: TX sink accepts.
REQ-011 SHALL have ports ret_i, input, 1; ret_id_i, input, 3: retire of an outstanding ID.
REQ-012 SHALL have ports busy_o, output, 8 (scoreboard bitmap) and outstanding_o, output, 4 (popcount of busy_o).

Function
REQ-013 SHALL hold an 8-bit busy scoreboard, one registered output stage (valid, id, payload, src) and a weight counter wcnt (3 bits).
REQ-014 SHALL define slot_free = ~tx_valid_o | tx_ready_i.
REQ-015 SHALL define a source as eligible when its valid is 1, busy[id] is 0 (registered value) and outstanding_o < OUTSTANDING_MAX.
REQ-016 SHALL grant at most one source per cycle, only when slot_free is 1.
REQ-017 SHALL, when both are eligible, grant ordered if wcnt < ORD_WEIGHT and otherwise grant unordered.
REQ-018 SHALL, when only one source is eligible, grant that source.
REQ-019 SHALL update wcnt as follows: ordered grant -> wcnt+1, saturating at ORD_WEIGHT; unordered grant -> 0; no grant -> hold.
REQ-020 SHALL assert ord_ready_o/unord_ready_o combinationally only in the cycle of that source's grant.
REQ-021 SHALL, on a grant, load id/payload/src into the output stage, set tx_valid_o next cycle, and set busy[id] next cycle (latency 1; throughput 1/cycle).
REQ-022 SHALL, when slot_free=1 and no grant, clear tx_valid_o next cycle; tx_id_o/tx_payload_o/tx_src_o hold their last values.
REQ-023 SHALL keep tx_id_o, tx_payload_o and tx_src_o stable while tx_valid_o=1 and tx_ready_i=0.
REQ-024 SHALL clear busy[ret_id_i] next cycle on ret_i=1; a retire of a non-busy ID SHALL be ignored.
REQ-025 SHALL apply both a retire of ID a and a grant of ID b in the same cycle, with a != b guaranteed by REQ-015; a retired ID SHALL become eligible no earlier than the following cycle.
REQ-026 SHALL never change the relative order of ordered grants: an ineligible ordered head blocks only the ordered stream, and unordered traffic continues.
REQ-027 SHALL combinationally derive outstanding_o from the registered busy bitmap.

Reset
REQ-028 SHALL, asynchronously while reset=0, force tx_valid_o=0, tx_id_o=0, tx_payload_o=0, tx_src_o=0, busy=0 and wcnt=0; ord_ready_o and unord_ready_o SHALL be 0 during reset.
REQ-029 SHALL have reset deassertion take effect at the next rising clk edge, with the first grant possible in that cycle.

Verification
REQ-030 Single ordered: ord id=3, payload=0xBEEF, tx_ready_i=1 -> ord_ready_o in cycle N; in N+1, tx_valid_o=1, id=3, payload 0xBEEF, src=1; busy_o=0x08.
REQ-031 Weighting: both heads always valid with fresh IDs, ORD_WEIGHT=2 -> tx_src_o sequence 1,1,0,1,1,0.
REQ-032 Busy block: ord id=5 outstanding, new ord head id=5 with unord id=1 -> unord granted, ordered stalls; ret_i id=5 in cycle M -> ordered granted no earlier than M+1.
REQ-033 Backpressure: tx_ready_i=0 for 4 cycles with an entry loaded -> outputs stable, both readies 0; tx_ready_i=1 -> pending entry and a new grant in the same cycle.
REQ-034 Limit: OUTSTANDING_MAX=2, two IDs issued, no retire -> no further grants, outstanding_o=2; retire one -> one grant follows.
REQ-035 Reset mid-operation: reset=0 asserted with tx_valid_o=1 and busy_o=0x36 -> immediately tx_valid_o=0 and busy_o=0; after release, normal grants resume.
